secksa_arbiter: RTL and testbench

- Shares one pipelined masked Kogge-Stone adder (SecKSA) between two requesters, A and B, in the Boolean-to-arithmetic conversion path.
- Arbitrates issue slots round-robin, gates issue on availability of fresh randomness, and tracks in-flight operations with a tag pipeline.
- Routes each result back to its originator and stalls the shared pipeline through the adder's ena when the originator cannot accept the result.

---
 rtl/secksa_arbiter.sv | 95 +++++++++
 tb/tb_secksa_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/secksa_arbiter.sv
// Two-requester front end for a shared pipelined masked Kogge-Stone adder.
// Define SECKSA_ARB_PRIO_EN for fixed priority to A; default build is round-robin.
module secksa_arbiter #(
  parameter int K_WIDTH = 32,
  parameter int N_SHARES = 8,
  localparam int MASKWIDTH = K_WIDTH * N_SHARES,
  localparam int LAT = $clog2(K_WIDTH - 1) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_vld,
  output logic                 a_rdy,
  input  logic [MASKWIDTH-1:0] a_x,
  input  logic [MASKWIDTH-1:0] a_y,
  input  logic                 b_vld,
  output logic                 b_rdy,
  input  logic [MASKWIDTH-1:0] b_x,
  input  logic [MASKWIDTH-1:0] b_y,
  output logic                 a_rsp_vld,
  input  logic                 a_rsp_rdy,
  output logic                 b_rsp_vld,
  input  logic                 b_rsp_rdy,
  output logic [MASKWIDTH-1:0] rsp_z,
  input  logic                 rnd_vld,
  output logic                 rnd_req,
  output logic                 ksa_ena,
  output logic                 ksa_dvld,
  output logic [MASKWIDTH-1:0] ksa_x,
  output logic [MASKWIDTH-1:0] ksa_y,
  input  logic [MASKWIDTH-1:0] ksa_z
);

  logic [LAT-1:0] vld_pipe_reg, vld_pipe_next;
  logic [LAT-1:0] own_pipe_reg, own_pipe_next;
  logic           head_vld, head_own;
  logic           stall, issue, grant_b;

  assign head_vld = vld_pipe_reg[LAT-1];
  assign head_own = own_pipe_reg[LAT-1];

  // The tag pipe mirrors the adder pipeline stage for stage, so it freezes with ena.
  assign stall   = head_vld & ~(head_own ? b_rsp_rdy : a_rsp_rdy);
  assign ksa_ena = ~stall & ~rst;
  assign issue   = ~stall & ~rst & rnd_vld & (a_vld | b_vld);

`ifdef SECKSA_ARB_PRIO_EN
  assign grant_b = b_vld & ~a_vld;
`else
  logic rr_ptr_reg;  // 0 = A has priority on the next contended slot

  assign grant_b = b_vld & (~a_vld | rr_ptr_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg <= 1'b0;
    end else if (issue) begin
      rr_ptr_reg <= ~grant_b;
    end
  end
`endif

  assign vld_pipe_next[0] = issue;
  assign own_pipe_next[0] = grant_b;

  generate
    for (genvar gi = 1; gi < LAT; gi++) begin : g_shift
      assign vld_pipe_next[gi] = vld_pipe_reg[gi-1];
      assign own_pipe_next[gi] = own_pipe_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_reg <= '0;
      own_pipe_reg <= '0;
    end else if (ksa_ena) begin
      vld_pipe_reg <= vld_pipe_next;
      own_pipe_reg <= own_pipe_next;
    end
  end

  assign a_rdy    = issue & ~grant_b;
  assign b_rdy    = issue & grant_b;
  assign rnd_req  = issue;
  assign ksa_dvld = issue;

  // Zero the operand bus when idle so old shares never reach the adder again.
  assign ksa_x = issue ? (grant_b ? b_x : a_x) : '0;
  assign ksa_y = issue ? (grant_b ? b_y : a_y) : '0;

  assign a_rsp_vld = head_vld & ~head_own;
  assign b_rsp_vld = head_vld & head_own;
  assign rsp_z     = ksa_z;

endmodule

// File: tb/tb_secksa_arbiter.sv
// Directed bench for secksa_arbiter with a behavioural masked-adder pipeline model.
module tb_secksa_arbiter;
  localparam int KW = 32;
  localparam int NS = 8;
  localparam int MW = KW * NS;
  localparam int LAT = $clog2(KW - 1) + 1;
`ifdef SECKSA_ARB_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic a_vld, a_rdy, b_vld, b_rdy;
  logic [MW-1:0] a_x, a_y, b_x, b_y;
  logic a_rsp_vld, a_rsp_rdy, b_rsp_vld, b_rsp_rdy;
  logic [MW-1:0] rsp_z;
  logic rnd_vld, rnd_req, ksa_ena, ksa_dvld;
  logic [MW-1:0] ksa_x, ksa_y, ksa_z;

  int n_vec = 0;
  int n_bad = 0;
  int unsigned seed = 1;

  typedef struct { logic owner; logic [31:0] sum; } exp_t;
  exp_t sb[$];

  typedef struct {
    logic a_v, b_v;
    logic [31:0] ax, ay, bx, by;
    logic rnd;
    logic [1:0] g_rr, g_pr;  // 0 none, 1 A, 2 B
  } vec_t;
  vec_t tbl[11];

  always #5 clk = ~clk;

  secksa_arbiter dut (
    .clk(clk), .rst(rst),
    .a_vld(a_vld), .a_rdy(a_rdy), .a_x(a_x), .a_y(a_y),
    .b_vld(b_vld), .b_rdy(b_rdy), .b_x(b_x), .b_y(b_y),
    .a_rsp_vld(a_rsp_vld), .a_rsp_rdy(a_rsp_rdy),
    .b_rsp_vld(b_rsp_vld), .b_rsp_rdy(b_rsp_rdy),
    .rsp_z(rsp_z), .rnd_vld(rnd_vld), .rnd_req(rnd_req),
    .ksa_ena(ksa_ena), .ksa_dvld(ksa_dvld),
    .ksa_x(ksa_x), .ksa_y(ksa_y), .ksa_z(ksa_z)
  );

  function automatic logic [MW-1:0] mask(input logic [31:0] v, input int unsigned s);
    logic [MW-1:0] r;
    logic [31:0] acc, sh;
    acc = v;
    r = '0;
    for (int i = 1; i < NS; i++) begin
      sh = (32'(s) * 32'h9E3779B1) ^ (32'(i) * 32'h85EBCA6B) ^ (32'h1 << i);
      r[i*KW +: KW] = sh;
      acc = acc ^ sh;
    end
    r[KW-1:0] = acc;
    return r;
  endfunction

  function automatic logic [31:0] comb(input logic [MW-1:0] v);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < NS; i++) acc = acc ^ v[i*KW +: KW];
    return acc;
  endfunction

  // Masked adder model: LAT stages frozen by ena, output re-masked with fresh shares.
  logic [MW-1:0] mx [LAT];
  logic [MW-1:0] my [LAT];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        mx[i] <= '0;
        my[i] <= '0;
      end
    end else if (ksa_ena) begin
      mx[0] <= ksa_x;
      my[0] <= ksa_y;
      for (int i = 1; i < LAT; i++) begin
        mx[i] <= mx[i-1];
        my[i] <= my[i-1];
      end
    end
  end
  assign ksa_z = mask(comb(mx[LAT-1]) + comb(my[LAT-1]), 32'd77);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Response scoreboard: every accepted result must match the oldest issued op.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && ((a_rsp_vld && a_rsp_rdy) || (b_rsp_vld && b_rsp_rdy))) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL rsp_unexpected: got response with empty scoreboard at %0t", $time);
      end else begin
        e = sb.pop_front();
        chk("rsp_owner", 32'(b_rsp_vld), 32'(e.owner));
        chk("rsp_sum", comb(rsp_z), e.sum);
      end
    end
  end

  task automatic drive(input logic av, input logic bv, input logic [31:0] ax, input logic [31:0] ay,
                       input logic [31:0] bx, input logic [31:0] by, input logic rv);
    a_vld = av; b_vld = bv; rnd_vld = rv;
    a_x = mask(ax, seed); a_y = mask(ay, seed + 1);
    b_x = mask(bx, seed + 2); b_y = mask(by, seed + 3);
    seed = seed + 4;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 0, 0, 0, 0, 1'b1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] g;
    logic [MW-1:0] zsave;
    a_rsp_rdy = 1'b1; b_rsp_rdy = 1'b1;
    drive(1'b1, 1'b1, 1, 2, 3, 4, 1'b1);
    #1 rst = 1'b1;

    // Reset: all outputs low even with requests and randomness present
    @(negedge clk);
    chk("rst_a_rdy", 32'(a_rdy), 0);
    chk("rst_b_rdy", 32'(b_rdy), 0);
    chk("rst_rnd_req", 32'(rnd_req), 0);
    chk("rst_dvld", 32'(ksa_dvld), 0);
    chk("rst_ena", 32'(ksa_ena), 0);
    chk("rst_rsp_vld", 32'({a_rsp_vld, b_rsp_vld}), 0);
    chk("rst_ksa_x", 32'(|ksa_x), 0);
    @(posedge clk); #1 rst = 1'b0;
    idle(2);

    // Single op from A: 5 + 3, response exactly LAT cycles after the grant
    drive(1'b1, 1'b0, 32'h5, 32'h3, 0, 0, 1'b1);
    sb.push_back('{1'b0, 32'h8});
    @(negedge clk);
    chk("single_a_rdy", 32'(a_rdy), 1);
    chk("single_b_rdy", 32'(b_rdy), 0);
    chk("single_rnd_req", 32'(rnd_req), 1);
    chk("single_dvld", 32'(ksa_dvld), 1);
    chk("single_ksa_x", comb(ksa_x), 32'h5);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 0, 0, 0, 0, 1'b1);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      chk("single_a_rsp_vld", 32'(a_rsp_vld), 32'(k == LAT));
      chk("single_b_rsp_vld", 32'(b_rsp_vld), 0);
      chk("single_a_rdy_low", 32'(a_rdy), 0);
      @(posedge clk); #1;
    end

    // Grant table: contention, wrap-around sums, starvation rows
    tbl[0]  = '{1'b0, 1'b1, 32'h0, 32'h0, 32'h10, 32'h20, 1'b1, 2'd2, 2'd2};
    tbl[1]  = '{1'b1, 1'b1, 32'hFFFFFFFF, 32'h1, 32'h12345678, 32'h11111111, 1'b1, 2'd1, 2'd1};
    tbl[2]  = '{1'b1, 1'b1, 32'h7, 32'h9, 32'h80000000, 32'h80000000, 1'b1, 2'd2, 2'd1};
    tbl[3]  = '{1'b1, 1'b1, 32'hDEADBEEF, 32'h1, 32'd100, 32'd200, 1'b1, 2'd1, 2'd1};
    tbl[4]  = '{1'b1, 1'b1, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h1, 32'h2, 1'b1, 2'd2, 2'd1};
    tbl[5]  = '{1'b1, 1'b1, 32'h3, 32'h4, 32'h5, 32'h6, 1'b0, 2'd0, 2'd0};
    tbl[6]  = '{1'b1, 1'b0, 32'h3, 32'h4, 32'h0, 32'h0, 1'b0, 2'd0, 2'd0};
    tbl[7]  = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 2'd0, 2'd0};
    tbl[8]  = '{1'b1, 1'b1, 32'h55555555, 32'h55555555, 32'h2, 32'h2, 1'b1, 2'd1, 2'd1};
    tbl[9]  = '{1'b0, 1'b1, 32'h0, 32'h0, 32'h7FFFFFFF, 32'h1, 1'b1, 2'd2, 2'd2};
    tbl[10] = '{1'b1, 1'b0, 32'hFFFFFFF0, 32'h20, 32'h0, 32'h0, 1'b1, 2'd1, 2'd1};
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].a_v, tbl[i].b_v, tbl[i].ax, tbl[i].ay, tbl[i].bx, tbl[i].by, tbl[i].rnd);
      g = PRIO ? tbl[i].g_pr : tbl[i].g_rr;
      if (g == 2'd1) sb.push_back('{1'b0, tbl[i].ax + tbl[i].ay});
      if (g == 2'd2) sb.push_back('{1'b1, tbl[i].bx + tbl[i].by});
      @(negedge clk);
      chk("tbl_a_rdy", 32'(a_rdy), 32'(g == 2'd1));
      chk("tbl_b_rdy", 32'(b_rdy), 32'(g == 2'd2));
      chk("tbl_rnd_req", 32'(rnd_req), 32'(g != 2'd0));
      chk("tbl_dvld", 32'(ksa_dvld), 32'(g != 2'd0));
      chk("tbl_ena", 32'(ksa_ena), 1);
      if (g == 2'd1) chk("tbl_ksa_y", comb(ksa_y), tbl[i].ay);
      else if (g == 2'd2) chk("tbl_ksa_y", comb(ksa_y), tbl[i].by);
      else chk("tbl_ksa_x_zero", 32'(|{ksa_x, ksa_y}), 0);
      @(posedge clk); #1;
    end
    idle(LAT + 2);

    // Randomness starvation, then issue in the same cycle rnd_vld rises
    drive(1'b1, 1'b0, 32'h100, 32'h200, 0, 0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("starve_a_rdy", 32'(a_rdy), 0);
      chk("starve_rnd_req", 32'(rnd_req), 0);
      chk("starve_dvld", 32'(ksa_dvld), 0);
      @(posedge clk); #1;
    end
    rnd_vld = 1'b1;
    sb.push_back('{1'b0, 32'h300});
    @(negedge clk);
    chk("starve_issue_a_rdy", 32'(a_rdy), 1);
    chk("starve_issue_rnd_req", 32'(rnd_req), 1);
    @(posedge clk); #1;
    idle(LAT + 2);

    // Backpressure: three ops, head held while A is not ready
    for (int j = 1; j <= 3; j++) begin
      drive(1'b1, 1'b0, 32'(j), 32'(j), 0, 0, 1'b1);
      sb.push_back('{1'b0, 32'(2 * j)});
      @(negedge clk);
      chk("bp_issue_a_rdy", 32'(a_rdy), 1);
      @(posedge clk); #1;
    end
    drive(1'b0, 1'b0, 0, 0, 0, 0, 1'b1);
    a_rsp_rdy = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (a_rsp_vld) break;
      @(posedge clk); #1;
    end
    chk("bp_head_arrived", 32'(a_rsp_vld), 1);
    chk("bp_stall_ena", 32'(ksa_ena), 0);
    zsave = rsp_z;
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 32'h40, 32'h2, 0, 0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_no_issue", 32'(a_rdy), 0);
      chk("bp_no_rnd_req", 32'(rnd_req), 0);
      chk("bp_ena_low", 32'(ksa_ena), 0);
      chk("bp_head_held", 32'(a_rsp_vld), 1);
      chk("bp_z_stable", 32'(rsp_z !== zsave), 0);
      @(posedge clk); #1;
    end
    a_rsp_rdy = 1'b1;
    sb.push_back('{1'b0, 32'h42});
    @(negedge clk);
    chk("bp_release_issue", 32'(a_rdy), 1);
    chk("bp_release_ena", 32'(ksa_ena), 1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 0, 0, 0, 0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("bp_back_to_back", 32'(a_rsp_vld), 1);
      @(posedge clk); #1;
    end
    idle(LAT + 2);

    // Reset with four ops in flight: nothing may come back
    for (int j = 0; j < 4; j++) begin
      drive(1'b1, 1'b1, 32'(j), 32'h1, 32'(j), 32'h2, 1'b1);
      @(posedge clk); #1;
    end
    drive(1'b0, 1'b0, 0, 0, 0, 0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_ena", 32'(ksa_ena), 0);
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("midrst_a_rsp_vld", 32'(a_rsp_vld), 0);
      chk("midrst_b_rsp_vld", 32'(b_rsp_vld), 0);
      @(posedge clk); #1;
    end

    // After reset the pointer favours A
    drive(1'b1, 1'b1, 32'hAB, 32'h1, 32'hCD, 32'h1, 1'b1);
    sb.push_back('{1'b0, 32'hAC});
    @(negedge clk);
    chk("postrst_a_rdy", 32'(a_rdy), 1);
    chk("postrst_b_rdy", 32'(b_rdy), 0);
    @(posedge clk); #1;
    idle(LAT + 2);

    chk("sb_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
